arith_cmpi_pipe: RTL and testbench

//  Streaming, multi-lane integer comparator with a runtime predicate and a valid/ready handshake.

---
 rtl/loom_arith_pkg.sv | 11 +
 rtl/arith_cmpi_lane.sv | 32 +++
 rtl/arith_cmpi_pipe.sv | 83 ++++++++
 tb/tb_arith_cmpi_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/loom_arith_pkg.sv
// loom_arith_pkg: shared types and helpers for the arith compare datapath.
package loom_arith_pkg;
    typedef enum logic [3:0] {
        PRED_EQ, PRED_NE, PRED_SLT, PRED_SLE, PRED_SGT,
        PRED_SGE, PRED_ULT, PRED_ULE, PRED_UGT, PRED_UGE
    } cmpi_pred_e;

    function automatic logic cmpi_pred_legal(cmpi_pred_e p);
        return p <= PRED_UGE;
    endfunction
endpackage

// File: rtl/arith_cmpi_lane.sv
// arith_cmpi_lane: one combinational compare lane; predicates 10-15 yield 0.
module arith_cmpi_lane
    import loom_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  cmpi_pred_e       i_pred,
    output logic             o_result
);
    logic w_eq, w_slt, w_ult;
    assign w_eq  = i_a == i_b;
    assign w_slt = $signed(i_a) < $signed(i_b);
    assign w_ult = i_a < i_b;
    always_comb begin
        o_result = 1'b0;
        case (i_pred)
            PRED_EQ:  o_result = w_eq;
            PRED_NE:  o_result = !w_eq;
            PRED_SLT: o_result = w_slt;
            PRED_SLE: o_result = w_slt | w_eq;
            PRED_SGT: o_result = !(w_slt | w_eq);
            PRED_SGE: o_result = !w_slt;
            PRED_ULT: o_result = w_ult;
            PRED_ULE: o_result = w_ult | w_eq;
            PRED_UGT: o_result = !(w_ult | w_eq);
            PRED_UGE: o_result = !w_ult;
            default:  o_result = 1'b0;
        endcase
    end
endmodule

// File: rtl/arith_cmpi_pipe.sv
// arith_cmpi_pipe: pipelined multi-lane comparator with valid/ready handshake.
// Define LOOM_CMPI_ERR_EN to enable the sticky illegal-predicate flag.
module arith_cmpi_pipe
    import loom_arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_pred,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_result,
    output logic                   err_sticky,
    input  logic                   err_clr
);
    cmpi_pred_e                   w_pred;
    logic [LANES-1:0]             w_res;
    logic [STAGES-1:0]            w_en;
    logic [STAGES-1:0]            r_v;
    logic [STAGES-1:0][LANES-1:0] r_res;
    logic                         w_full;
    logic                         w_in_xfer;

    assign w_pred = cmpi_pred_e'(in_pred);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        arith_cmpi_lane #(.WIDTH(WIDTH)) u_lane (
            .i_a     (in_a[i*WIDTH +: WIDTH]),
            .i_b     (in_b[i*WIDTH +: WIDTH]),
            .i_pred  (w_pred),
            .o_result(w_res[i])
        );
    end

    // A stage may load when the consumer takes the head or any downstream stage has a hole.
    always_comb begin
        w_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_full  = w_full & r_v[k];
            w_en[k] = out_ready | !w_full;
        end
    end

    assign in_ready   = w_en[0];
    assign w_in_xfer  = in_valid & in_ready;
    assign out_valid  = r_v[STAGES-1];
    assign out_result = r_res[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_res <= '0;
        end else begin
            if (w_en[0]) r_v[0] <= in_valid;
            if (w_in_xfer) r_res[0] <= w_res;
            for (int k = 1; k < STAGES; k++) begin
                if (w_en[k]) r_v[k] <= r_v[k-1];
                if (w_en[k] && r_v[k-1]) r_res[k] <= r_res[k-1];
            end
        end
    end

`ifdef LOOM_CMPI_ERR_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else if (err_clr) r_err <= 1'b0;
        else if (w_in_xfer && !cmpi_pred_legal(w_pred)) r_err <= 1'b1;
    end
    assign err_sticky = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err_sticky       = 1'b0;
`endif
endmodule

// File: tb/tb_arith_cmpi_pipe.sv
// tb_arith_cmpi_pipe: directed table plus corner sequences for arith_cmpi_pipe (W=8, L=4, S=2).
module tb_arith_cmpi_pipe;
    localparam int W = 8;
    localparam int L = 4;
    localparam int S = 2;
`ifdef LOOM_CMPI_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] in_pred = '0;
    logic [L*W-1:0] in_a = '0;
    logic [L*W-1:0] in_b = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [L-1:0] out_result;
    logic err_sticky;
    logic err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arith_cmpi_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pred(in_pred), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    typedef struct {
        logic [3:0]     p;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [L-1:0]   e;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    // Integer-domain reference: signed operands are mapped to -128..127 explicitly.
    function automatic logic [L-1:0] model(input logic [3:0] p, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) begin
            int ua, ub, sa, sb;
            ua = int'(a[i*W +: W]);
            ub = int'(b[i*W +: W]);
            sa = ua > 127 ? ua - 256 : ua;
            sb = ub > 127 ? ub - 256 : ub;
            case (p)
                0: r[i] = ua == ub;
                1: r[i] = ua != ub;
                2: r[i] = sa < sb;
                3: r[i] = sa <= sb;
                4: r[i] = sa > sb;
                5: r[i] = sa >= sb;
                6: r[i] = ua < ub;
                7: r[i] = ua <= ub;
                8: r[i] = ua > ub;
                9: r[i] = ua >= ub;
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic run_vec(input string n, input vec_t v);
        @(negedge clk);
        in_valid = 1'b1; in_pred = v.p; in_a = v.a; in_b = v.b;
        #1 chk({n, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_pred = 4'($urandom);
        chk({n, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({n, "_valid"}, out_valid, 1);
        chk({n, "_result"}, out_result, v.e);
    endtask

    vec_t tbl[12];
    logic [L-1:0] q[$];
    logic [L-1:0] held;
    logic [L-1:0] expq;
    int acc, rx, first_c, last_c, stale;

    initial begin
        tbl[0]  = '{4'd0,  32'h00090705, 32'h01090605, 4'b0101};
        tbl[1]  = '{4'd2,  32'hFFFFFFFF, 32'h01010101, 4'hF};
        tbl[2]  = '{4'd6,  32'hFFFFFFFF, 32'h01010101, 4'h0};
        tbl[3]  = '{4'd9,  32'hFFFFFFFF, 32'h01010101, 4'hF};
        tbl[4]  = '{4'd3,  32'h807F00FF, 32'h7F8000FF, 4'b1011};
        tbl[5]  = '{4'd4,  32'h807F00FF, 32'h7F8000FF, 4'b0100};
        tbl[6]  = '{4'd8,  32'h807F00FF, 32'h7F8000FF, 4'b1000};
        tbl[7]  = '{4'd7,  32'h807F00FF, 32'h7F8000FF, 4'b0111};
        tbl[8]  = '{4'd1,  32'h807F00FF, 32'h7F8000FF, 4'b1100};
        tbl[9]  = '{4'd5,  32'h807F00FF, 32'h7F8000FF, 4'b0111};
        tbl[10] = '{4'd12, 32'h12345678, 32'h12345678, 4'h0};
        tbl[11] = '{4'd15, 32'h00000000, 32'h00000000, 4'h0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_err", err_sticky, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);
        chk("err_legal_only", err_sticky, 0);
        run_vec("vec10", tbl[10]);
        chk("err_set", err_sticky, ERR_EN);
        run_vec("vec11", tbl[11]);
        chk("err_hold", err_sticky, ERR_EN);
        err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("err_cleared", err_sticky, 0);
        in_valid = 1'b1; in_pred = 4'd13; err_clr = 1'b1;
        @(negedge clk) in_valid = 1'b0; err_clr = 1'b0;
        chk("err_clr_priority", err_sticky, 0);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: 5 offers with the consumer stalled.
        out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_pred = (acc == 0) ? 4'd0 : (acc == 1) ? 4'd6 : 4'd1;
            in_a = (acc == 0) ? 32'h01020304 : 32'h00000000;
            in_b = (acc == 0) ? 32'h01000304 : 32'h01010101;
            #1;
            if (in_ready) begin
                q.push_back(model(in_pred, in_a, in_b));
                acc++;
            end
            if (c == 2) held = out_result;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_held", out_result, held);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("bp_drain_valid%0d", c), out_valid, 1);
            expq = q.size() > 0 ? q.pop_front() : 4'hx;
            chk($sformatf("bp_drain_res%0d", c), out_result, expq);
            @(negedge clk);
        end
        chk("bp_empty", out_valid, 0);

        // Back-to-back stream of 100 random beats.
        q.delete(); rx = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 120 && rx < 100; c++) begin
            if (out_valid) begin
                expq = q.size() > 0 ? q.pop_front() : 4'hx;
                if (out_result !== expq) chk($sformatf("stream_res%0d", rx), out_result, expq);
                if (first_c < 0) first_c = c;
                last_c = c;
                rx++;
            end
            if (c < 100) begin
                in_valid = 1'b1; in_pred = 4'($urandom_range(0, 9));
                in_a = $urandom; in_b = (c % 4 == 0) ? in_a : $urandom;
                #1;
                if (!in_ready) chk("stream_in_ready", in_ready, 1);
                q.push_back(model(in_pred, in_a, in_b));
            end else in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream_count", rx, 100);
        chk("stream_first", first_c, 2);
        chk("stream_last", last_c, 101);
        chk("stream_err", err_sticky, 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_pred = 4'd0; in_a = '0; in_b = '0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rm_full", out_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("rm_async_drop", out_valid, 0);
        chk("rm_result_clr", out_result, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("rm_in_ready", in_ready, 1);
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rm_no_stale", stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
